// File: rtl/noc_rr_receiver.sv
// Input-side packet arbiter: round-robin channel grant held until the tail flit,
// with a mid-packet stall watchdog and a per-packet flit limit.
module noc_rr_receiver #(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = 4,
  parameter int PORTS_NUM = 4,
  parameter int BUS_SIZE  = DATA_SIZE + ADDR_SIZE + 1,
  parameter int MAX_FLITS = 16,
  parameter int TIMEOUT   = 32,
  parameter int PORT_W    = $clog2(PORTS_NUM + 1)
) (
  input  logic                              clk,
  input  logic                              a_rst,
  input  logic                              is_full,
  input  logic [PORTS_NUM:0]                wr_ready_in,
  input  logic [(PORTS_NUM+1)*BUS_SIZE-1:0] data_i,
  output logic                              wr_req,
  output logic [PORTS_NUM:0]                r_ready_out,
  output logic [BUS_SIZE-1:0]               data_o,
  output logic [PORT_W-1:0]                 cur_port,
  output logic                              busy,
  output logic                              pkt_abort
);

  localparam int CH      = PORTS_NUM + 1;
  localparam int FLIT_W  = $clog2(MAX_FLITS + 1);
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t              state, state_nxt;
  logic [PORT_W-1:0]   last_port, last_port_nxt, cur_port_nxt;
  logic [PORT_W-1:0]   winner, cand;
  logic                found;
  logic [FLIT_W-1:0]   flit_cnt, flit_cnt_nxt;
  logic [STALL_W-1:0]  stall_cnt, stall_cnt_nxt;
  logic [BUS_SIZE-1:0] data_nxt, cur_flit;
  logic [BUS_SIZE-1:0] chan_flit [CH];
  logic                cur_ready, wr_req_nxt, abort_nxt;
  logic [PORTS_NUM:0]  r_ready_nxt;

  always_comb begin
    for (int unsigned k = 0; k < CH; k++) begin
      chan_flit[k] = data_i[k*BUS_SIZE +: BUS_SIZE];
    end
  end

  assign cur_ready = wr_ready_in[cur_port];
  assign cur_flit  = chan_flit[cur_port];

  // Scan starts one past the last served channel, so every channel waits at most one packet per peer.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned i = 1; i <= CH; i++) begin
      cand = PORT_W'((32'(last_port) + i) % CH);
      if (!found && wr_ready_in[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_port_nxt  = cur_port;
    last_port_nxt = last_port;
    flit_cnt_nxt  = flit_cnt;
    stall_cnt_nxt = stall_cnt;
    data_nxt      = data_o;
    wr_req_nxt    = 1'b0;
    r_ready_nxt   = '0;
    abort_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!is_full && found) begin
          cur_port_nxt  = winner;
          flit_cnt_nxt  = '0;
          stall_cnt_nxt = '0;
          state_nxt     = XFER;
        end
      end
      XFER: begin
        if (cur_ready && !is_full) begin
          data_nxt              = cur_flit;
          wr_req_nxt            = 1'b1;
          r_ready_nxt[cur_port] = 1'b1;
          if (flit_cnt != FLIT_W'(MAX_FLITS)) flit_cnt_nxt = flit_cnt + 1'b1;
          stall_cnt_nxt         = '0;
          state_nxt             = ACK;
        end else if (!cur_ready) begin
          // Backpressure alone never trips the watchdog; only a silent source does.
          if (stall_cnt >= STALL_W'(TIMEOUT - 1)) begin
            abort_nxt     = 1'b1;
            last_port_nxt = cur_port;
            state_nxt     = IDLE;
          end else begin
            stall_cnt_nxt = stall_cnt + 1'b1;
          end
        end
      end
      ACK: begin
        if (data_o[ADDR_SIZE]) begin
          last_port_nxt = cur_port;
          state_nxt     = IDLE;
        end else if (flit_cnt == FLIT_W'(MAX_FLITS)) begin
          abort_nxt     = 1'b1;
          last_port_nxt = cur_port;
          state_nxt     = IDLE;
        end else begin
          state_nxt = XFER;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state       <= IDLE;
      last_port   <= PORT_W'(PORTS_NUM);
      cur_port    <= '0;
      flit_cnt    <= '0;
      stall_cnt   <= '0;
      data_o      <= '0;
      wr_req      <= 1'b0;
      r_ready_out <= '0;
      pkt_abort   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_port   <= last_port_nxt;
      cur_port    <= cur_port_nxt;
      flit_cnt    <= flit_cnt_nxt;
      stall_cnt   <= stall_cnt_nxt;
      data_o      <= data_nxt;
      wr_req      <= wr_req_nxt;
      r_ready_out <= r_ready_nxt;
      pkt_abort   <= abort_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: doc/noc_rr_receiver.md
Name: noc_rr_receiver

Overview:
Input-side packet arbiter for the PGNoC switch. It selects one of PORTS_NUM+1 input channels with fair round-robin arbitration and locks onto that channel until the packet's tail flit has passed. Each flit is forwarded into the switch buffer through a wr_req/is_full write interface. It adds fairness, a stall watchdog, a packet-length limit and status outputs on top of the existing fixed-scan receiver behaviour.

Parameters:
DATA_SIZE, 32, payload bits per flit
ADDR_SIZE, 4, address bits per flit; bit ADDR_SIZE of a flit is the tail flag
PORTS_NUM, 4, number of neighbour ports; channel count is PORTS_NUM+1 (the extra channel is local)
BUS_SIZE, DATA_SIZE+ADDR_SIZE+1, flit width
MAX_FLITS, 16, maximum flits per packet before a forced release
TIMEOUT, 32, idle cycles tolerated mid-packet before a forced release
PORT_W, clog2(PORTS_NUM+1), width of the port index

Ports:
clk  in  1  clock; all state changes on the rising edge
a_rst  in  1  reset, asynchronous, active-high
is_full  in  1  downstream buffer full; no write may be issued while high
wr_ready_in  in  PORTS_NUM+1  per-channel flag: the source holds a valid flit
data_i  in  (PORTS_NUM+1)*BUS_SIZE  flits; channel k occupies bits [k*BUS_SIZE +: BUS_SIZE]
wr_req  out  1  one-cycle write strobe to the buffer, qualifying data_o
r_ready_out  out  PORTS_NUM+1  one-hot, one-cycle ack to the source whose flit was taken
data_o  out  BUS_SIZE  forwarded flit
cur_port  out  PORT_W  currently locked channel
busy  out  1  high while a channel is locked (state != IDLE)
pkt_abort  out  1  one-cycle pulse when a packet is force-released

Behaviour:
- All outputs are registered. On reset: state=IDLE; wr_req=0; r_ready_out=0; data_o=0; cur_port=0; busy=0; pkt_abort=0; last_port=PORTS_NUM; flit_cnt=0; stall_cnt=0.
- Reset asserted mid-packet abandons the packet immediately. No pkt_abort is generated.
- wr_req, r_ready_out and pkt_abort default to 0 every cycle and are high only in the cycle after the event that sets them.
- States: IDLE, XFER, ACK.
- IDLE, arbitration:
  - Arbitration happens only if is_full=0.
  - Search channels (last_port+1) mod (PORTS_NUM+1) upward with wrap. The first channel with wr_ready_in high wins.
  - The search is combinational and completes in one cycle.
  - On a winner: cur_port<=winner, flit_cnt<=0, stall_cnt<=0, state<=XFER.
  - With no requester, or with is_full=1, the block stays in IDLE.
- XFER:
  - If wr_ready_in[cur_port]=1 and is_full=0: data_o<=data_i slice of cur_port, wr_req<=1, r_ready_out[cur_port]<=1, flit_cnt<=flit_cnt+1, stall_cnt<=0, state<=ACK.
  - Otherwise stall_cnt increments. It counts only when wr_ready_in[cur_port]=0, not on is_full backpressure.
  - If stall_cnt reaches TIMEOUT-1 and flit_cnt>0: pkt_abort<=1, last_port<=cur_port, state<=IDLE.
  - If flit_cnt=0, the watchdog also applies; the granted source must present a flit within TIMEOUT cycles.
- ACK (gap cycle so the source can advance its flit):
  - If data_o[ADDR_SIZE]=1 (tail): last_port<=cur_port, state<=IDLE.
  - Else if flit_cnt=MAX_FLITS: pkt_abort<=1, last_port<=cur_port, state<=IDLE.
  - Else state<=XFER.
- Throughput: one flit per 2 cycles. Grant to first write: 1 cycle after the IDLE decision.
- Requests on other channels are ignored while a channel is locked. wr_ready_in changes on them have no effect.
- Only the locked channel's wr_ready_in and data_i are sampled. X on unused channels must not propagate.
- A single-flit packet has its tail flag set on the first flit.
- Counters saturate and never wrap. flit_cnt width is clog2(MAX_FLITS+1); stall_cnt width is clog2(TIMEOUT+1).

Test Plan:
- Only channel 2 requests, single flit with tail=1, data 0x...A5 -> cycle+1 XFER; cycle+2 wr_req=1, r_ready_out=5'b00100, data_o=flit; back to IDLE; busy low after ACK.
- All 5 channels continuously request single-flit packets after reset -> grant order 0,1,2,3,4,0; each channel gets exactly one grant per 5 packets.
- Channel 1 sends a 3-flit packet while channel 3 also requests -> three consecutive wr_req pulses from channel 1 (tail on the 3rd), then channel 3 is granted; no channel-3 flit appears in between.
- is_full held high for 10 cycles mid-packet -> no wr_req, no r_ready_out, no pkt_abort; transfer resumes the cycle after is_full falls.
- Channel 0 sends 1 flit without tail, then drops wr_ready_in -> pkt_abort pulses after TIMEOUT stall cycles; next arbitration starts from channel 1.
- Non-tail flits streamed for MAX_FLITS=16 flits -> 16 wr_req pulses, then pkt_abort=1 in the cycle after the 16th ACK and state IDLE. Separately: a_rst asserted mid-packet -> all outputs 0 immediately, and the next grant goes to channel 0.
